// File: rtl/aes_pkg.sv
// Shared AES definitions: CTR increment stage state encoding and slice geometry.
package aes_pkg;

  localparam int unsigned AES_CTR_SLICE_W    = 16;
  localparam int unsigned AES_CTR_NUM_SLICES = 128 / AES_CTR_SLICE_W;

  typedef enum logic [0:0] {
    CTR_IDLE,
    CTR_INCR
  } aes_ctr_e;

endpackage

// File: rtl/aes_ctr.sv
// AES CTR-mode counter increment: one slice per cycle, stopping at the first slice
// that does not carry out, with per-slice write enables back to the IV register.
module aes_ctr
  import aes_pkg::*;
#(
  parameter int unsigned SLICE_W = AES_CTR_SLICE_W,
  localparam int unsigned NUM_SLICES = 128 / SLICE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  incr_i,
  input  logic [127:0]          ctr_i,
  output logic                  ready_o,
  output logic [127:0]          ctr_o,
  output logic [NUM_SLICES-1:0] ctr_we_o,
  output logic                  wrap_o,
  output logic                  err_o
);

  localparam int unsigned IdxW = $clog2(NUM_SLICES);

  aes_ctr_e          state_q, state_d;
  logic [127:0]      ctr_q, ctr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [SLICE_W:0]  sum;
  logic              carry;

  assign sum   = {1'b0, ctr_q[32'(idx_q) * SLICE_W +: SLICE_W]} + {{SLICE_W{1'b0}}, 1'b1};
  assign carry = sum[SLICE_W];

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    ready_o  = 1'b0;
    ctr_we_o = '0;
    ctr_o    = ctr_q;
    unique case (state_q)
      CTR_IDLE: begin
        ready_o = 1'b1;
        if (incr_i) begin
          ctr_d   = ctr_i;
          idx_d   = '0;
          state_d = CTR_INCR;
        end
      end
      CTR_INCR: begin
        ctr_o[32'(idx_q) * SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
        ctr_we_o[idx_q] = 1'b1;
        ctr_d = ctr_o;
        // Requests while busy are dropped and only flagged.
        err_d = incr_i;
        if (!carry) begin
          state_d = CTR_IDLE;
        end else if (idx_q == IdxW'(NUM_SLICES - 1)) begin
          state_d = CTR_IDLE;
          wrap_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = CTR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTR_IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule
